// File: rtl/gray_sync_decoder_pkg.sv
// Shared definitions for the Gray pointer synchronizer/decoder:
// the state encoding and the default parameter values.
package gray_sync_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/gray_sync_decoder_converter.sv
// Combinational Gray/binary converter (module graycode_converter).
// convert_dir = 0 decodes Gray to binary; convert_dir = 1 encodes binary to Gray.
module graycode_converter #(
    parameter int data_width  = 4,
    parameter int convert_dir = 0
) (
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] data_out
);

    generate
        if (convert_dir == 0) begin : g_gray_to_bin
            // Each binary bit is the XOR of every Gray bit at or above it.
            always_comb begin
                logic [data_width-1:0] bin;
                bin                 = '0;
                bin[data_width-1]   = data_in[data_width-1];
                for (int i = data_width - 2; i >= 0; i--) begin
                    bin[i] = bin[i+1] ^ data_in[i];
                end
                data_out = bin;
            end
        end else begin : g_bin_to_gray
            assign data_out = data_in ^ (data_in >> 1);
        end
    endgenerate

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray-coded pointer, decodes it and presents each change as a
// handshaked entry with a modular step. Optional checking: GRAY_SYNC_ERR_CHECK_EN.
module gray_sync_decoder
    import gray_sync_decoder_pkg::*;
#(
    parameter int data_width  = DEFAULT_DATA_WIDTH,
    parameter int sync_stages = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] gray_in,
    output logic [data_width-1:0] bin_out,
    output logic [data_width-1:0] step_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  err_multi
);

    logic [data_width-1:0] sync_q [sync_stages];
    logic [data_width-1:0] synced;
    logic [data_width-1:0] prev_synced;
    logic [data_width-1:0] synced_bin;
    logic                  gray_event;

    state_t                state_q, state_d;
    logic [data_width-1:0] bin_q, bin_d;
    logic [data_width-1:0] step_q, step_d;
    logic [data_width-1:0] pend_bin_q, pend_bin_d;
    logic [data_width-1:0] pend_step_q, pend_step_d;
    logic                  overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < sync_stages; i++) begin
                sync_q[i] <= '0;
            end
            prev_synced <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < sync_stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_synced <= synced;
        end
    end

    assign synced     = sync_q[sync_stages-1];
    assign gray_event = (synced != prev_synced);

    graycode_converter #(
        .data_width (data_width),
        .convert_dir(0)
    ) u_converter (
        .data_in (synced),
        .data_out(synced_bin)
    );

    // bin_q doubles as the last emitted value, so steps are always taken against it.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        step_d      = step_q;
        pend_bin_d  = pend_bin_q;
        pend_step_d = pend_step_q;
        overrun_d   = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (gray_event) begin
                    bin_d   = synced_bin;
                    step_d  = synced_bin - bin_q;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_ready) begin
                    if (gray_event) begin
                        bin_d  = synced_bin;
                        step_d = synced_bin - bin_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (gray_event) begin
                    pend_bin_d  = synced_bin;
                    pend_step_d = synced_bin - bin_q;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (out_ready) begin
                    bin_d  = pend_bin_q;
                    step_d = pend_step_q;
                    if (gray_event) begin
                        pend_bin_d  = synced_bin;
                        pend_step_d = synced_bin - pend_bin_q;
                    end else begin
                        state_d = ST_VALID;
                    end
                end else if (gray_event) begin
                    pend_bin_d  = synced_bin;
                    pend_step_d = synced_bin - bin_q;
                    overrun_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            step_q      <= '0;
            pend_bin_q  <= '0;
            pend_step_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            step_q      <= step_d;
            pend_bin_q  <= pend_bin_d;
            pend_step_q <= pend_step_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = (state_q != ST_IDLE);
    assign bin_out   = bin_q;
    assign step_out  = step_q;
    assign overrun   = overrun_q;

`ifdef GRAY_SYNC_ERR_CHECK_EN
    localparam logic [data_width-1:0] ONE = {{(data_width-1){1'b0}}, 1'b1};

    logic [data_width-1:0] gray_diff;
    logic                  multi_bit;
    logic                  err_q;

    // A legal Gray step flips exactly one bit; more than one set bit is an error.
    assign gray_diff = synced ^ prev_synced;
    assign multi_bit = gray_event && ((gray_diff & (gray_diff - ONE)) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= multi_bit;
        end
    end

    assign err_multi = err_q;
`else
    assign err_multi = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed testbench for gray_sync_decoder (data_width=4, sync_stages=2);
// expected values are hand-computed constants.
module tb_gray_sync_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic [3:0] step_out;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       err_multi;

    int testsRun;
    int testsFailed;

    // Single-bit Gray walk from 0011 up to 1000 and the matching binary values.
    logic [3:0] walkGray [14] = '{4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                  4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] walkBin  [14] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                  4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    gray_sync_decoder #(
        .data_width (4),
        .sync_stages(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .bin_out  (bin_out),
        .step_out (step_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .err_multi(err_multi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] gray, input logic ready,
                                 input logic resetValue);
        gray_in   = gray;
        out_ready = ready;
        rst       = resetValue;
    endtask

    // Advance n rising edges, then settle 1 ns so outputs are sampled off the edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        applyStimulus(4'b0000, 1'b0, 1'b1);
        waitCycles(2);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_bin", 32'(bin_out), 32'd0);
        checkOutput("reset_step", 32'(step_out), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_err", 32'(err_multi), 32'd0);

        for (int i = 0; i < 10; i++) begin
            waitCycles(1);
            checkOutput("idle_zero_valid", 32'(out_valid), 32'd0);
        end

        applyStimulus(4'b0001, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("lat_edge1_valid", 32'(out_valid), 32'd0);
        waitCycles(1);
        checkOutput("lat_edge2_valid", 32'(out_valid), 32'd0);
        waitCycles(1);
        checkOutput("first_valid", 32'(out_valid), 32'd1);
        checkOutput("first_bin", 32'(bin_out), 32'd1);
        checkOutput("first_step", 32'(step_out), 32'd1);
        checkOutput("first_err", 32'(err_multi), 32'd0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("first_accept_idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(walkGray[i], 1'b1, 1'b0);
            waitCycles(3);
            checkOutput("walk_valid", 32'(out_valid), 32'd1);
            checkOutput("walk_bin", 32'(bin_out), 32'(walkBin[i]));
            checkOutput("walk_step", 32'(step_out), 32'd1);
            waitCycles(1);
            checkOutput("walk_idle", 32'(out_valid), 32'd0);
        end

        applyStimulus(4'b0000, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("wrap_valid", 32'(out_valid), 32'd1);
        checkOutput("wrap_bin", 32'(bin_out), 32'd0);
        checkOutput("wrap_step", 32'(step_out), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("wrap_idle", 32'(out_valid), 32'd0);

        applyStimulus(4'b0001, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("ovr_load_valid", 32'(out_valid), 32'd1);
        checkOutput("ovr_load_bin", 32'(bin_out), 32'd1);
        checkOutput("ovr_load_step", 32'(step_out), 32'd1);
        waitCycles(1);
        checkOutput("ovr_pend_overrun", 32'(overrun), 32'd0);
        checkOutput("ovr_pend_bin_hold", 32'(bin_out), 32'd1);
        waitCycles(1);
        checkOutput("ovr_overrun", 32'(overrun), 32'd1);
        checkOutput("ovr_bin_hold", 32'(bin_out), 32'd1);
        checkOutput("ovr_step_hold", 32'(step_out), 32'd1);
        checkOutput("ovr_valid_hold", 32'(out_valid), 32'd1);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("ovr_release_valid", 32'(out_valid), 32'd1);
        checkOutput("ovr_release_bin", 32'(bin_out), 32'd3);
        checkOutput("ovr_release_step", 32'(step_out), 32'd2);
        waitCycles(1);
        checkOutput("ovr_release_idle", 32'(out_valid), 32'd0);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        applyStimulus(4'b0110, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("rstpend_valid", 32'(out_valid), 32'd1);
        checkOutput("rstpend_bin", 32'(bin_out), 32'd4);
        checkOutput("rstpend_step", 32'(step_out), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("rstpend_after_valid", 32'(out_valid), 32'd0);
        checkOutput("rstpend_after_overrun", 32'(overrun), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            waitCycles(1);
            checkOutput("rstpend_no_delivery", 32'(out_valid), 32'd0);
        end

        applyStimulus(4'b0011, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("multi_valid", 32'(out_valid), 32'd1);
        checkOutput("multi_bin", 32'(bin_out), 32'd2);
        checkOutput("multi_step", 32'(step_out), 32'd2);
`ifdef GRAY_SYNC_ERR_CHECK_EN
        checkOutput("multi_err_pulse", 32'(err_multi), 32'd1);
`else
        checkOutput("multi_err_tied", 32'(err_multi), 32'd0);
`endif
        waitCycles(1);
        checkOutput("multi_err_clear", 32'(err_multi), 32'd0);
        checkOutput("multi_bin_hold", 32'(bin_out), 32'd2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
